// File: rtl/ysyx_mem_pkg.sv
// Shared types and defaults for the ysyx memory arbiter slice.
package ysyx_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    HAND = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/ysyx_rr_arb2.sv
// Two-input round-robin grant; on a tie the master not granted last wins.
module ysyx_rr_arb2
  import ysyx_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_ifu,
  input  logic req_lsu,
  output logic gnt_ifu,
  output logic gnt_lsu
);

  owner_e last_q;

  always_comb begin
    gnt_ifu = en & req_ifu & (~req_lsu | (last_q == OWN_LSU));
    gnt_lsu = en & req_lsu & (~req_ifu | (last_q == OWN_IFU));
  end

  // Resetting to LSU lets the IFU win the first tie after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_LSU;
    end else if (gnt_ifu) begin
      last_q <= OWN_IFU;
    end else if (gnt_lsu) begin
      last_q <= OWN_LSU;
    end
  end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// IFU/LSU to single memory port arbiter with response timeout and orphan absorb.
//   state | meaning
//   IDLE  | waiting for a request; grants when no orphan response is pending
//   REQ   | presenting the captured request until the memory accepts it
//   RSP   | waiting for the memory response, bounded by TIMEOUT cycles
//   HAND  | holding the response to the owner until it is consumed
module ysyx_mem_arbiter
  import ysyx_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rsp_err,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_e              state_q, state_d;
  owner_e              owner_q;
  logic                orphan_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic grant_en;
  logic gnt_ifu;
  logic gnt_lsu;
  logic rsp_take;
  logic timeout_hit;

  // Gating with rst keeps req_ready low while reset is held.
  assign grant_en    = rst & (state_q == IDLE) & ~orphan_q;
  assign rsp_take    = (state_q == RSP) & mem_rsp_valid;
  assign timeout_hit = (state_q == RSP) & ~mem_rsp_valid & (cnt_q == CNT_LAST);

  ysyx_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (grant_en),
    .req_ifu (ifu_req_valid),
    .req_lsu (lsu_req_valid),
    .gnt_ifu (gnt_ifu),
    .gnt_lsu (gnt_lsu)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rdata     = '0;
    ifu_rsp_err   = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rdata     = '0;
    lsu_rsp_err   = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_wen       = 1'b0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    mem_rsp_ready = orphan_q;
    busy          = (state_q != IDLE) | orphan_q;
    case (state_q)
      IDLE: begin
        ifu_req_ready = gnt_ifu;
        lsu_req_ready = gnt_lsu;
        if (gnt_ifu || gnt_lsu) state_d = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = addr_q;
        mem_wen       = wen_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
        if (mem_req_ready) state_d = RSP;
      end
      RSP: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid || timeout_hit) state_d = HAND;
      end
      HAND: begin
        if (owner_q == OWN_IFU) begin
          ifu_rsp_valid = 1'b1;
          ifu_rdata     = rdata_q;
          ifu_rsp_err   = err_q;
          if (ifu_rsp_ready) state_d = IDLE;
        end else begin
          lsu_rsp_valid = 1'b1;
          lsu_rdata     = rdata_q;
          lsu_rsp_err   = err_q;
          if (lsu_rsp_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= OWN_IFU;
      orphan_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // Fetches are reads: no write data and an all-zero byte mask.
      if (gnt_ifu) begin
        owner_q <= OWN_IFU;
        addr_q  <= ifu_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end else if (gnt_lsu) begin
        owner_q <= OWN_LSU;
        addr_q  <= lsu_addr;
        wen_q   <= lsu_wen;
        wdata_q <= lsu_wdata;
        wmask_q <= lsu_wmask;
      end

      if ((state_q == REQ) && mem_req_ready) begin
        cnt_q <= '0;
      end else if ((state_q == RSP) && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (rsp_take) begin
        rdata_q <= mem_rdata;
        err_q   <= mem_rsp_err;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end

      // A response racing the timeout is taken normally, so no orphan is left.
      if (timeout_hit) begin
        orphan_q <= 1'b1;
      end else if (orphan_q && mem_rsp_valid) begin
        orphan_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Directed bench for ysyx_mem_arbiter: vector table plus hand-written corner sequences.
module tb_ysyx_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        is_lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          req_dly;
    int          rsp_dly;
    int          ack_dly;
    logic [31:0] mrdata;
    logic        merr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t vecs[5];

  ysyx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rdata     (ifu_rdata),
    .ifu_rsp_err   (ifu_rsp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rdata     (lsu_rdata),
    .lsu_rsp_err   (lsu_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rdata     (mem_rdata),
    .mem_rsp_err   (mem_rsp_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Single-master transaction in lockstep; every cycle is checked at its expected position.
  task automatic do_vec(input vec_t v);
    @(negedge clk);
    if (v.is_lsu) begin
      lsu_req_valid = 1'b1; lsu_addr = v.addr; lsu_wen = v.wen;
      lsu_wdata = v.wdata; lsu_wmask = v.wmask;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = v.addr;
    end
    #1 chk("vec_grant", {ifu_req_ready, lsu_req_ready}, v.is_lsu ? 2'b01 : 2'b10);
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    for (int d = 0; d <= v.req_dly; d++) begin
      mem_req_ready = (d == v.req_dly);
      #1 chk("vec_req_fields", {mem_req_valid, mem_addr, mem_wen, mem_wmask},
             {1'b1, v.addr, v.wen, v.exp_mask});
      if (v.is_lsu) chk("vec_req_wdata", mem_wdata, v.wdata);
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    for (int d = 0; d <= v.rsp_dly; d++) begin
      mem_rsp_valid = (d == v.rsp_dly);
      mem_rdata     = (d == v.rsp_dly) ? v.mrdata : 32'hFFFF_FFFF;
      mem_rsp_err   = (d == v.rsp_dly) ? v.merr : 1'b0;
      #1 chk("vec_rsp_wait", {mem_rsp_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 4'b1000);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0; mem_rdata = '0; mem_rsp_err = 1'b0;
    for (int d = 0; d <= v.ack_dly; d++) begin
      if (v.is_lsu) lsu_rsp_ready = (d == v.ack_dly);
      else          ifu_rsp_ready = (d == v.ack_dly);
      #1;
      if (v.is_lsu)
        chk("vec_hand_lsu", {lsu_rsp_valid, ifu_rsp_valid, lsu_rdata, lsu_rsp_err},
            {2'b10, v.exp_rdata, v.exp_err});
      else
        chk("vec_hand_ifu", {ifu_rsp_valid, lsu_rsp_valid, ifu_rdata, ifu_rsp_err},
            {2'b10, v.exp_rdata, v.exp_err});
      @(negedge clk);
    end
    ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
    #1 chk("vec_idle", {busy, ifu_rsp_valid, lsu_rsp_valid}, 3'b000);
  endtask

  // Services a just-granted transaction with zero wait states and checks the owner sees rd.
  task automatic svc(input logic own_lsu, input logic [31:0] rd, input string nm);
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = rd; mem_rsp_err = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rdata = '0; ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
    #1;
    if (own_lsu) chk(nm, {lsu_rsp_valid, ifu_rsp_valid, lsu_rdata}, {2'b10, rd});
    else         chk(nm, {ifu_rsp_valid, lsu_rsp_valid, ifu_rdata}, {2'b10, rd});
    @(negedge clk);
    ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
  endtask

  task automatic both_req(input logic exp_lsu, input string nm);
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_wmask = 4'hF;
    #1 chk(nm, {ifu_req_ready, lsu_req_ready}, exp_lsu ? 2'b01 : 2'b10);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 32'h8000_0000, 1'b0, 32'h0,         4'h0, 0, 0, 0,
                32'h0000_0413, 1'b0, 32'h0000_0413, 1'b0, 4'h0};
    vecs[1] = '{1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3, 5, 0, 0,
                32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 4'h3};
    vecs[2] = '{1'b1, 32'h8000_0004, 1'b0, 32'h0,         4'hF, 1, 2, 0,
                32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 4'hF};
    vecs[3] = '{1'b0, 32'h8000_0008, 1'b0, 32'h0,         4'h0, 0, 0, 3,
                32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 4'h0};
    vecs[4] = '{1'b1, 32'h8000_0FFC, 1'b0, 32'h0,         4'hC, 0, 3, 1,
                32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0, 4'hC};

    rst = 1'b0;
    ifu_req_valid = 0; ifu_addr = '0; ifu_rsp_ready = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; lsu_rsp_ready = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0; mem_rsp_err = 0;
    repeat (3) @(negedge clk);
    #1 chk("reset_ctrl", {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid,
                          mem_req_valid, mem_rsp_ready, busy}, 7'b0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post_reset_idle", {busy, mem_req_valid, mem_rsp_ready}, 3'b000);

    // Ties alternate starting with the IFU.
    both_req(1'b0, "tie1_ifu");
    svc(1'b0, 32'h0000_0001, "tie1_rsp");
    both_req(1'b1, "tie2_lsu");
    svc(1'b1, 32'h0000_0002, "tie2_rsp");
    both_req(1'b0, "tie3_ifu");
    svc(1'b0, 32'h0000_0003, "tie3_rsp");
    both_req(1'b1, "tie4_lsu");
    svc(1'b1, 32'h0000_0004, "tie4_rsp");

    for (int i = 0; i < 5; i++) do_vec(vecs[i]);

    // Timeout with a pending IFU request that must wait for the orphan to be absorbed.
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; lsu_wmask = 4'hF;
    #1 chk("to_grant", {ifu_req_ready, lsu_req_ready}, 2'b01);
    @(negedge clk);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0020;
    @(negedge clk);
    mem_req_ready = 1'b0;
    n = 0;
    #1;
    while (lsu_rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("to_rsp_cycles", n, 64);
    chk("to_err_rsp", {lsu_rsp_valid, lsu_rsp_err, lsu_rdata, ifu_req_ready, ifu_rsp_valid},
        {2'b11, 32'h0, 2'b00});
    lsu_rsp_ready = 1'b1;
    @(negedge clk);
    lsu_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("orphan_block", {ifu_req_ready, busy, mem_rsp_ready}, 3'b011);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1 chk("orphan_absorb", {ifu_req_ready, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}, 4'b0100);
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    #1 chk("orphan_cleared", {ifu_req_ready, busy}, 2'b10);
    svc(1'b0, 32'h1111_2222, "orphan_ifu_data");

    // Owner stalls in HAND while the LSU waits.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
    #1 chk("stall_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; lsu_wmask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_hold", {ifu_rsp_valid, ifu_rdata, lsu_req_ready}, {1'b1, 32'h0BAD_F00D, 1'b0});
      @(negedge clk);
    end
    ifu_rsp_ready = 1'b1;
    #1 chk("stall_ack", {ifu_rsp_valid, ifu_rdata, lsu_req_ready}, {1'b1, 32'h0BAD_F00D, 1'b0});
    @(negedge clk);
    ifu_rsp_ready = 1'b0;
    #1 chk("stall_next_grant", {lsu_req_ready, ifu_rsp_valid}, 2'b10);
    svc(1'b1, 32'h7777_0000, "stall_lsu_rsp");

    // Reset asserted while in RSP; last grant was IFU so only a reset of last lets IFU win.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    #1 chk("rst_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0050; lsu_wmask = 4'hF;
    #1 chk("rst_in_rsp", {mem_rsp_ready, busy}, 2'b11);
    rst = 1'b0;
    #1 chk("rst_ctrl_zero", {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, lsu_req_ready,
                             lsu_rsp_valid, lsu_rsp_err, mem_req_valid, mem_wen,
                             mem_rsp_ready, busy}, 10'b0);
    chk("rst_addr_zero", {mem_addr, mem_wmask}, 64'h0);
    chk("rst_data_zero", {ifu_rdata, lsu_rdata}, 64'h0);
    chk("rst_wdata_zero", mem_wdata, 64'h0);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1 chk("rst_tie_ifu", {ifu_req_ready, lsu_req_ready, busy}, 3'b100);
    svc(1'b0, 32'h0000_5555, "rst_after_rsp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
